// File: rtl/cipher_pkg.sv
// Shared constants and sequencer state encoding for the Caesar-style decrypt path.
package cipher_pkg;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_0   = 8'd48;
  localparam logic [7:0] ASCII_9   = 8'd57;
  localparam logic [7:0] ASCII_A   = 8'd65;
  localparam logic [7:0] ASCII_Z   = 8'd90;
  localparam logic [7:0] ASCII_a   = 8'd97;
  localparam logic [7:0] ASCII_z   = 8'd122;

  localparam logic [7:0] DIGIT_MOD = 8'd10;
  localparam logic [7:0] ALPHA_MOD = 8'd26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PROC = 2'd2,
    EMIT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/decrypt.sv
// Combinational single-character decrypt: shifts digits and letters backwards
// by the key, wrapping inside their own class; everything else passes through.
module decrypt
  import cipher_pkg::*;
(
  input  logic [7:0] ascii_in,
  input  logic [7:0] shift_value,
  output logic [7:0] ascii_out
);

  logic [7:0] d_shift, a_shift;

  assign d_shift = shift_value % DIGIT_MOD;
  assign a_shift = shift_value % ALPHA_MOD;

  // Adding the modulus before subtracting keeps every intermediate non-negative.
  always_comb begin
    ascii_out = ascii_in;
    if (ascii_in >= ASCII_0 && ascii_in <= ASCII_9)
      ascii_out = ASCII_0 + (ascii_in - ASCII_0 + DIGIT_MOD - d_shift) % DIGIT_MOD;
    else if (ascii_in >= ASCII_A && ascii_in <= ASCII_Z)
      ascii_out = ASCII_A + (ascii_in - ASCII_A + ALPHA_MOD - a_shift) % ALPHA_MOD;
    else if (ascii_in >= ASCII_a && ascii_in <= ASCII_z)
      ascii_out = ASCII_a + (ascii_in - ASCII_a + ALPHA_MOD - a_shift) % ALPHA_MOD;
  end

endmodule

// File: rtl/msg_decrypt_sequencer.sv
// Buffers a NUL-terminated message, decrypts it in place one char per cycle,
// then streams the plaintext out over valid/ready with an end-of-message flag.
module msg_decrypt_sequencer
  import cipher_pkg::*;
#(
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy,
  output logic [LEN_W-1:0] msg_len
);

  localparam int              AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  seq_state_t       state, state_nxt;
  logic [7:0]       msg_buf [MAX_LEN];
  logic [LEN_W-1:0] len_q, idx_q;
  logic [7:0]       key_q, cur_char, dec_char;
  logic             in_fire, out_fire, is_nul, idx_last;

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign in_fire   = in_valid && in_ready;
  assign is_nul    = (in_char == ASCII_NUL);
  assign idx_last  = (idx_q == len_q - ONE);
  assign cur_char  = msg_buf[idx_q[AW-1:0]];

  assign out_valid = (state == EMIT);
  assign out_fire  = out_valid && out_ready;
  assign out_char  = out_valid ? cur_char : 8'h00;
  assign out_last  = out_valid && idx_last;
  assign busy      = (state != IDLE);
  assign msg_len   = len_q;

  decrypt u_decrypt (
    .ascii_in   (cur_char),
    .shift_value(key_q),
    .ascii_out  (dec_char)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_fire && !is_nul) state_nxt = LOAD;
      // A full buffer closes the message without waiting for a terminator.
      LOAD: if (in_fire && (is_nul || (len_q + ONE == FULL))) state_nxt = PROC;
      PROC: if (idx_last) state_nxt = EMIT;
      EMIT: if (out_fire && idx_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // len_q doubles as the write pointer while loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_fire) begin
          key_q <= key_in;
          len_q <= is_nul ? '0 : ONE;
          idx_q <= '0;
        end
        LOAD: if (in_fire && !is_nul) len_q <= len_q + ONE;
        PROC: idx_q <= idx_last ? '0 : idx_q + ONE;
        EMIT: if (out_fire) idx_q <= idx_last ? '0 : idx_q + ONE;
        default: ;
      endcase
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_fire && !is_nul)
      msg_buf[0] <= in_char;
    else if (state == LOAD && in_fire && !is_nul)
      msg_buf[len_q[AW-1:0]] <= in_char;
    else if (state == PROC)
      msg_buf[idx_q[AW-1:0]] <= dec_char;
  end

endmodule

// File: tb/tb_msg_decrypt_sequencer.sv
// Directed bench for msg_decrypt_sequencer with hand-computed plaintext.
module tb_msg_decrypt_sequencer;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       key_in;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_char;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_last;
  logic             busy;
  logic [LEN_W-1:0] msg_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msg_decrypt_sequencer #(.MAX_LEN(MAX_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_char (out_char),
    .out_last (out_last),
    .busy     (busy),
    .msg_len  (msg_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, input logic [7:0] k);
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_char  = c;
    key_in   = k;
    step();
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic send_str(input string s, input logic [7:0] k);
    for (int i = 0; i < s.len(); i++) send_char(s[i], k);
  endtask

  // Consumes a whole message; out_ready follows the 4-entry pattern cyclically.
  task automatic expect_msg(input string tag, input string s, input logic [3:0] rdy_pat);
    int i = 0;
    int cyc = 0;
    int guard = 0;
    while (i < s.len()) begin
      out_ready = rdy_pat[cyc % 4];
      if (out_valid) begin
        chk({tag, "_char"}, {24'd0, out_char}, {24'd0, s[i]});
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, (i == s.len() - 1)});
        if (out_ready) i++;
      end
      cyc++;
      guard++;
      if (guard > 200) begin
        chk({tag, "_timeout"}, 32'd0, 32'd1);
        break;
      end
      step();
    end
    out_ready = 1'b1;
    chk({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy_after"},  {31'd0, busy},      32'd0);
  endtask

  initial begin
    rst = 1'b1; key_in = '0; in_valid = 1'b0; in_char = '0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_out_char",  {24'd0, out_char},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_msg_len",   32'(msg_len),       32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // "Khoor"/3 with latency check: out_valid first high after edge T+5
    send_str("Khoor", 8'd3);
    send_char(8'h00, 8'd3);
    chk("t1_busy",    {31'd0, busy},     32'd1);
    chk("t1_in_rdy",  {31'd0, in_ready}, 32'd0);
    chk("t1_len",     32'(msg_len),      32'd5);
    repeat (4) step();
    chk("t1_valid_T4", {31'd0, out_valid}, 32'd0);
    step();
    chk("t1_valid_T5", {31'd0, out_valid}, 32'd1);
    expect_msg("t1", "Hello", 4'b1111);
    chk("t1_len_hold", 32'(msg_len), 32'd5);

    // digits wrap by 13 mod 10 = 3, punctuation passes through
    send_str("0a!", 8'd13);
    send_char(8'h00, 8'd13);
    expect_msg("t2", "7n!", 4'b1111);
    chk("t2_len", 32'(msg_len), 32'd3);

    // 29 mod 26 = 3; key change after first char is ignored
    send_char("a", 8'd29);
    send_char(8'h00, 8'd0);
    expect_msg("t3", "x", 4'b1111);

    // full buffer without terminator
    for (int i = 0; i < MAX_LEN; i++) send_char("B", 8'd1);
    chk("t4_in_rdy", {31'd0, in_ready}, 32'd0);
    chk("t4_len",    32'(msg_len),      32'd16);
    expect_msg("t4", "AAAAAAAAAAAAAAAA", 4'b1111);
    send_char(8'h00, 8'd1);
    chk("t4_trail_busy", {31'd0, busy},      32'd0);
    chk("t4_trail_len",  32'(msg_len),       32'd0);
    step();
    chk("t4_trail_valid", {31'd0, out_valid}, 32'd0);

    // backpressure: out_ready 1,0,0,1 repeating (bit0 first)
    send_str("Khoor", 8'd3);
    send_char(8'h00, 8'd3);
    expect_msg("t5", "Hello", 4'b1001);

    // reset during EMIT of the 3rd char
    send_str("Khoor", 8'd3);
    send_char(8'h00, 8'd3);
    begin
      int g = 0;
      while (!out_valid && g < 50) begin step(); g++; end
    end
    chk("t6_valid", {31'd0, out_valid}, 32'd1);
    step(); step();
    chk("t6_third", {24'd0, out_char}, {24'd0, 8'h6c});
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_last",  {31'd0, out_last},  32'd0);
    chk("t6_rst_char",  {24'd0, out_char},  32'd0);
    chk("t6_rst_busy",  {31'd0, busy},      32'd0);
    chk("t6_rst_rdy",   {31'd0, in_ready},  32'd1);
    chk("t6_rst_len",   32'(msg_len),       32'd0);
    step();
    rst = 1'b0;
    step();
    send_char("1", 8'd1);
    send_char(8'h00, 8'd1);
    expect_msg("t6", "0", 4'b1111);

    // empty message
    send_char(8'h00, 8'd5);
    chk("t7_busy",  {31'd0, busy},      32'd0);
    chk("t7_len",   32'(msg_len),       32'd0);
    chk("t7_valid", {31'd0, out_valid}, 32'd0);
    step(); step();
    chk("t7_valid2", {31'd0, out_valid}, 32'd0);
    chk("t7_busy2",  {31'd0, busy},      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_decrypt_sequencer.md
Name: msg_decrypt_sequencer

Overview:
- Upstream framing and buffering stage for the combinational `decrypt` character stage.
- Collects a NUL-terminated ASCII message from a byte stream and latches one shift key per message.
- Walks the stored message through one `decrypt` instance, one character per cycle.
- Streams the plaintext to the display path over a valid/ready interface with an end-of-message marker.

Parameters:
- MAX_LEN, 16: message buffer depth in characters; legal range 2..256.
- LEN_W, $clog2(MAX_LEN+1): width of length/index counters (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  8  shift value; sampled only on the first accepted character of a message.
- in_valid  in  1  in_char is valid.
- in_ready  out  1  block can accept in_char this cycle.
- in_char  in  8  ASCII character; 8'h00 terminates the message.
- out_valid  out  1  out_char is valid.
- out_ready  in  1  downstream accepts out_char.
- out_char  out  8  decrypted ASCII character.
- out_last  out  1  qualifies the final character of a message (valid only with out_valid).
- busy  out  1  high in every state except IDLE.
- msg_len  out  LEN_W  length of the current or most recent message; holds until the next message starts.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - in_ready=1, out_valid=0, out_last=0, out_char=0, busy=0, msg_len=0.
  - key register=0, all pointers=0.
  - Buffer contents are don't-care.
- Handshakes:
  - A transfer occurs on a rising clk edge with valid&&ready.
  - out_char and out_last stay stable while out_valid&&!out_ready.
  - in_ready is registered/state-decoded only; it never depends combinationally on in_valid.
- States:
  - IDLE: in_ready=1. On an accepted char:
    - Latch key_in.
    - If char==8'h00: empty message. Stay in IDLE, no output, msg_len=0.
    - Otherwise: store char at buf[0], wr_ptr=1, go to LOAD. msg_len updates as wr_ptr advances.
  - LOAD: in_ready=1. On an accepted char:
    - If char==8'h00: len=wr_ptr, go to PROC. The terminator is not stored.
    - Else: store at buf[wr_ptr], increment wr_ptr.
    - If wr_ptr reaches MAX_LEN after the store, go to PROC immediately with len=MAX_LEN; in_ready drops the next cycle.
    - A following 8'h00 is then treated as a new empty message in IDLE, so it is harmless.
  - PROC: in_ready=0.
    - Each cycle: buf[idx] <= decrypt(buf[idx], key), then idx++.
    - After idx==len-1 is written, idx=0 and go to EMIT.
    - Takes exactly len cycles.
  - EMIT: in_ready=0, out_valid=1, out_char=buf[idx], out_last=(idx==len-1).
    - On a transfer: idx++.
    - On the transfer with out_last=1: go to IDLE; out_valid drops the next cycle.
- Latency:
  - Terminator accepted at edge T: PROC occupies T+1..T+len, and out_valid is first high in the cycle after edge T+len.
  - With MAX_LEN fill, timing counts from the MAX_LEN-th character's edge.
- Decrypt arithmetic is the shared `decrypt` stage, unmodified:
  - Digits: shift mod 10, wrapping within '0'..'9'.
  - Upper and lower case letters: shift mod 26, wrapping within their own range.
  - All other bytes pass through.
  - The key applies to the whole message; a key_in change mid-message is ignored.
- rst asserted in any state aborts the message immediately. Partial output is not completed and nothing is replayed.
- in_valid is ignored in PROC and EMIT; no overflow is possible because in_ready=0 there.

Decomposition:
- Shared package `cipher_pkg`:
  - ASCII constants: ASCII_NUL=8'h00, ASCII_0=48, ASCII_9=57, ASCII_A=65, ASCII_Z=90, ASCII_a=97, ASCII_z=122.
  - DIGIT_MOD=10, ALPHA_MOD=26.
  - State enum seq_state_t {IDLE, LOAD, PROC, EMIT}.
- One sub-module: the existing `decrypt`, instantiated once with ascii_in=buf[idx], shift_value=key, writing back in PROC.
- The buffer is an inferred register array MAX_LEN x 8 inside this block.

Test Plan:
- key_in=3, send "Khoor",8'h00 -> out "Hello" ('H','e','l','l','o'), out_last only on 'o', msg_len=5, first out_valid 6 cycles after terminator edge (len=5 PROC cycles, then EMIT).
- key_in=13, send "0a!",00 -> out '7','n','!'. Digit shift is 13 mod 10=3 with wrap; '!' passes through unchanged.
- key_in=29, send "a",00 -> out 'x'. 29 mod 26=3 and 'a' wraps to 'x'. key_in changed to 0 after the first char has no effect.
- MAX_LEN=16, send 16 'B' with key 1 and no terminator -> in_ready drops after the 16th; output is 16 'A' with out_last on the 16th. A trailing 00 is then absorbed in IDLE with no output.
- Backpressure: out_ready toggled 1,0,0,1 during EMIT of "Khoor"/3 -> no character lost or duplicated; out_char stable while stalled.
- rst pulsed while EMIT is on the 3rd char, then "1",00 with key 1 -> outputs reset values immediately; next message outputs only '0' with out_last=1.
- Empty message: 00 in IDLE -> busy stays 0, no out_valid, msg_len=0.
